// File: rtl/AMITypes.sv
// AmorphOS AMI application-port request/response types shared by memory clients.
package AMITypes;

   typedef struct packed {
      logic         valid;
      logic         isWrite;
      logic [63:0]  addr;
      logic [511:0] data;
      logic [63:0]  size;
   } AMIRequest;

   typedef struct packed {
      logic         valid;
      logic [511:0] data;
      logic [63:0]  size;
   } AMIResponse;

endpackage

// File: rtl/dnn_ami_arb_pkg.sv
// Shared constants, arbiter state encoding and helpers for the DNNWeaver AMI port arbiter.
package dnn_ami_arb_pkg;

   localparam int unsigned MAX_OUTSTANDING_DEF = 16;

   typedef enum logic {
      ARB_OPEN,
      ARB_HELD
   } arb_state_t;

   function automatic int unsigned id_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
      return (cur + 1 >= n) ? 0 : cur + 1;
   endfunction

endpackage

// File: rtl/dnn_ami_tag_fifo.sv
// Synchronous requester-ID FIFO; wrap-bit pointers give full/empty/count without a separate counter.
module dnn_ami_tag_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned W     = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic [W-1:0]               pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   always_comb begin
      empty    = (wr_ptr == rd_ptr);
      full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      count    = wr_ptr - rd_ptr;
      pop_data = mem[rd_ptr[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/dnn_ami_port_arb.sv
// Round-robin sharing of one AMI port among NUM_REQ DNNWeaver memory engines,
// with in-order routing of read responses back to the issuing engine.
module dnn_ami_port_arb
   import AMITypes::*;
   import dnn_ami_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ         = 3,
   parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
   parameter int unsigned ID_W            = id_width(NUM_REQ)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  AMIRequest                          req_in [NUM_REQ],
   output logic [NUM_REQ-1:0]                 req_grant_out,
   output AMIResponse                         resp_out [NUM_REQ],
   input  logic [NUM_REQ-1:0]                 resp_grant_in,
   output AMIRequest                          mem_req,
   input  logic                               mem_req_grant,
   input  AMIResponse                         mem_resp,
   output logic                               mem_resp_grant,
   output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
   output logic                               err_orphan_resp
);
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   arb_state_t          state;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     lock_id;
   logic [NUM_REQ-1:0]  eligible;
   logic [ID_W-1:0]     win_id;
   logic                win_found;
   logic                grant;
   logic                fifo_push;
   logic                fifo_pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic [ID_W-1:0]     head_id;
   logic [CNT_W-1:0]    fifo_count;

   // fifo_full is a function of registered pointers only, so a pop in the
   // same cycle cannot open a slot for a new read until the next cycle.
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req_in[i].valid && (req_in[i].isWrite || !fifo_full);
      end
   end

   always_comb begin
      int unsigned idx;
      idx       = 0;
      win_found = 1'b0;
      win_id    = rr_ptr;
      if (state == ARB_HELD) begin
         win_id    = lock_id;
         win_found = eligible[lock_id];
      end else begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!win_found && eligible[ID_W'(idx)]) begin
               win_found = 1'b1;
               win_id    = ID_W'(idx);
            end
         end
      end
   end

   always_comb begin
      mem_req       = req_in[win_id];
      mem_req.valid = win_found && !rst;
      grant         = mem_req.valid && mem_req_grant;
      fifo_push     = grant && !mem_req.isWrite;
      req_grant_out = '0;
      if (grant) begin
         req_grant_out[win_id] = 1'b1;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         resp_out[i]       = mem_resp;
         resp_out[i].valid = !rst && !fifo_empty && mem_resp.valid && (ID_W'(i) == head_id);
      end
      // With nothing outstanding the response has no owner and is drained.
      mem_resp_grant = !rst && mem_resp.valid && (fifo_empty || resp_grant_in[head_id]);
      fifo_pop       = !rst && mem_resp.valid && !fifo_empty && resp_grant_in[head_id];
      outstanding    = fifo_count;
   end

   dnn_ami_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .W     (ID_W)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (win_id),
      .pop       (fifo_pop),
      .pop_data  (head_id),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ARB_OPEN;
         rr_ptr          <= '0;
         lock_id         <= '0;
         err_orphan_resp <= 1'b0;
      end else begin
         if (grant) begin
            state  <= ARB_OPEN;
            rr_ptr <= ID_W'(rr_next(32'(win_id), NUM_REQ));
         end else if (mem_req.valid) begin
            state   <= ARB_HELD;
            lock_id <= win_id;
         end else begin
            state <= ARB_OPEN;
         end
         if (mem_resp.valid && fifo_empty) begin
            err_orphan_resp <= 1'b1;
         end
      end
   end

endmodule

// File: doc/dnn_ami_port_arb.md
Name: dnn_ami_port_arb

Overview:
- Shares one AMI application port between NUM_REQ DNNWeaver memory requesters (e.g. input-read, weight-read, output-write engines).
- Sits between the accelerator's memory engines and one AmorphOSMem2SDRAM app/port slot (AMIRequest/AMIResponse from AMITypes).
- Round-robin arbitrates requests and tracks outstanding reads in issue order.
- Routes each in-order AMI read response back to the requester that issued it.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- MAX_OUTSTANDING, 16, read-ordering FIFO depth; power of two.
- ID_W, $clog2(NUM_REQ), requester index width (derived; do not override).

Ports:
- clk  in  1  user clock.
- rst  in  1  synchronous, active-high reset.
- req_in  in  AMIRequest[NUM_REQ]  per-requester request (valid, isWrite, addr, data, size).
- req_grant_out  out  1[NUM_REQ]  request accepted this cycle.
- resp_out  out  AMIResponse[NUM_REQ]  per-requester response.
- resp_grant_in  in  1[NUM_REQ]  requester consumes resp_out this cycle.
- mem_req  out  AMIRequest  to AMI port.
- mem_req_grant  in  1  AMI accepted mem_req.
- mem_resp  in  AMIResponse  from AMI port; in-order per port.
- mem_resp_grant  out  1  response consumed.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  reads in flight.
- err_orphan_resp  out  1  sticky; response arrived with no read outstanding.

Behaviour:
- Reset: rr pointer=0, lock clear, FIFO empty, outstanding=0, err_orphan_resp=0. All req_grant_out, resp_out.valid, mem_req.valid and mem_resp_grant are 0 from the cycle rst is high.
- Eligibility:
  - A requester is eligible when its req_in.valid=1.
  - A read (isWrite=0) is additionally eligible only when the FIFO is not full.
  - Writes are never blocked by FIFO full.
- Arbitration:
  - Combinational round-robin search starting at rr pointer.
  - The winner drives mem_req directly, with zero-cycle pass-through.
- Lock: once mem_req.valid=1 without mem_req_grant, selection is held until grant. Required because the AMI needs a stable valid request.
- Grant cycle (mem_req_grant & mem_req.valid):
  - req_grant_out[winner]=1 for exactly that cycle.
  - Lock releases; rr pointer <= winner+1 mod NUM_REQ.
  - If read: push winner ID into FIFO, outstanding+1.
- Response routing:
  - With FIFO not empty, head ID h: resp_out[h] = mem_resp; other resp_out.valid=0.
  - mem_resp_grant = mem_resp.valid & resp_grant_in[h].
  - On that handshake: pop FIFO, outstanding-1.
- Simultaneous read grant and response pop in one cycle: push and pop both occur, outstanding unchanged. FIFO full plus simultaneous pop still blocks new reads that cycle, so eligibility uses the registered full flag.
- Orphan response: mem_resp.valid with FIFO empty.
  - mem_resp_grant=1 so the response is drained and dropped.
  - err_orphan_resp <= 1, cleared only by rst.
- FIFO wrap-around: pointers are ID_W-wide entries, index width log2(MAX_OUTSTANDING)+1 with a wrap bit; full/empty come from pointer compare.
- rst mid-operation:
  - In-flight bookkeeping is discarded.
  - Upstream AMI must be reset simultaneously; post-reset responses count as orphans.

Decomposition:
- dnn_ami_arb_pkg: holds ID_W helper function, MAX_OUTSTANDING default, and rr_next() function.
- AMIRequest/AMIResponse remain in AMITypes.
- Sub-module dnn_ami_tag_fifo: synchronous ID FIFO with push/pop/full/empty/count, same clk/rst.

Test Plan:
- Single requester read: req 1 read addr 0x40; mem_req_grant next cycle; response 2 cycles later. Expect req_grant_out[1] one cycle, resp_out[1].valid with data, outstanding 0→1→0.
- Three requesters valid continuously, grant every cycle. Expect grant order 0,1,2,0,1,2; no starvation.
- Lock: req 0 valid, mem_req_grant low for 5 cycles while req 2 asserts. Expect mem_req.addr stable from req 0 until grant, then req 2 next.
- Ordering: reads from 2,0,1 issued; three responses D0,D1,D2 returned. Expect D0→req2, D1→req0, D2→req1. Response stall while resp_grant_in[2]=0 holds mem_resp_grant=0.
- FIFO full: 16 reads with no responses. Expect 17th read not granted, concurrent write granted; one response pop allows the read the following cycle.
- Orphan and reset:
  - mem_resp.valid with nothing outstanding: expect mem_resp_grant=1, err_orphan_resp=1.
  - rst pulse mid-burst: expect all outputs 0 and outstanding=0 next cycle.
